fcb_apbs_gen2: RTL

- Second-generation APB slave front-end for the FCB CSR space.
- Width-parametrised with APB4 byte strobes.
- Decodes an address window and flags out-of-window accesses with PSLVERR.
- Uses a req/ack handshake toward the CSR block, so CSR latency is variable.
- Stalls writes while the write-mask window is active, with a timeout error path.
- Sits between the SoC APB fabric and the FCB CSR/checksum logic.

---
 rtl/fcb_apbs_pkg.sv | 22 ++
 rtl/fcb_apbs_gen2_if.sv | 25 ++
 rtl/fcb_apbs_stall_tmr.sv | 36 +++
 rtl/fcb_apbs_gen2.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/fcb_apbs_pkg.sv
// Shared types, default widths and the address-window check for the FCB APB slave.
package fcb_apbs_pkg;

    localparam int unsigned DefAddrW    = 32;
    localparam int unsigned DefDataW    = 32;
    localparam int unsigned DefStallTmo = 255;

    // Explicit encodings keep the state values stable for debug probes.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StResp = 2'd3
    } apbs_state_e;

    // Inclusive window check. Operands are zero-extended so that one function
    // serves every ADDR_W up to 64.
    function automatic logic in_window(logic [63:0] addr, logic [63:0] base, logic [63:0] last);
        return (addr >= base) && (addr <= last);
    endfunction

endpackage

// File: rtl/fcb_apbs_gen2_if.sv
// APB4 bus bundle between the SoC fabric (master) and the FCB slave front-end.
interface fcb_apbs_gen2_if #(
    parameter int unsigned ADDR_W = fcb_apbs_pkg::DefAddrW,
    parameter int unsigned DATA_W = fcb_apbs_pkg::DefDataW
) ();
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_W-1:0]     paddr;
    logic [DATA_W-1:0]     pwdata;
    logic [DATA_W/8-1:0]   pstrb;
    logic                  pready;
    logic                  pslverr;
    logic [DATA_W-1:0]     prdata;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  pready, pslverr, prdata
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output pready, pslverr, prdata
    );
endinterface

// File: rtl/fcb_apbs_stall_tmr.sv
// Write-mask stall counter with terminal-count flag. Counts while inc_i is high,
// clears whenever clr_i is high and saturates at STALL_TMO.
module fcb_apbs_stall_tmr #(
    parameter int unsigned STALL_TMO = fcb_apbs_pkg::DefStallTmo
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic clr_i,
    output logic tmo_o
);
    localparam int unsigned CntW = $clog2(STALL_TMO + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tmo_o = (cnt_q == CntW'(STALL_TMO));

    // Next count: clear has priority, then saturating increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !tmo_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/fcb_apbs_gen2.sv
// Second-generation APB4 slave front-end for the FCB CSR space.
// Decodes [BASE_ADDR, LAST_ADDR], forwards accesses over a req/ack handshake,
// stalls writes while the write-mask window is active.
// Optional: define FCB_APBS_STALL_TIMEOUT_EN to error a write after STALL_TMO
// stall cycles instead of stalling indefinitely.
module fcb_apbs_gen2
    import fcb_apbs_pkg::*;
#(
    parameter int unsigned       ADDR_W    = DefAddrW,
    parameter int unsigned       DATA_W    = DefDataW,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(32'h0000_0FFF),
    parameter int unsigned       STALL_TMO = DefStallTmo
) (
    input  logic                  FCB_CLK,
    input  logic                  FCB_RST_N,
    fcb_apbs_gen2_if.slave        apb,
    input  logic                  CFG_APBS_fmask_win_write_operation,
    output logic                  APBS_CSR_req,
    output logic                  APBS_CSR_we,
    output logic [ADDR_W-1:0]     APBS_CSR_addr,
    output logic [DATA_W-1:0]     APBS_CSR_wdata,
    output logic [DATA_W/8-1:0]   APBS_CSR_wstrb,
    input  logic                  CSR_APBS_ack,
    input  logic [DATA_W-1:0]     CSR_APBS_rdata,
    input  logic                  CSR_APBS_err,
    output logic [DATA_W-1:0]     fAPBS_CHKS_wdata
);
    localparam int unsigned StrbW = DATA_W / 8;

    if (DATA_W % 8 != 0) begin : g_bad_data_w
        $error("DATA_W must be a multiple of 8");
    end
    if (STALL_TMO < 1) begin : g_bad_stall_tmo
        $error("STALL_TMO must be at least 1");
    end

    apbs_state_e         state_q, state_d;
    logic [ADDR_W-1:0]   offset_q, offset_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [StrbW-1:0]    strb_q, strb_d;
    logic                we_q, we_d;
    logic                in_win_q, in_win_d;
    logic                abort_q, abort_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   chks_q, chks_d;
    logic                stall_tmo;
    logic                stalling;

    // A masked in-window write that the master is still holding.
    assign stalling = (state_q == StReq) && apb.psel && in_win_q && we_q
                      && CFG_APBS_fmask_win_write_operation;

`ifdef FCB_APBS_STALL_TIMEOUT_EN
    fcb_apbs_stall_tmr #(
        .STALL_TMO (STALL_TMO)
    ) u_stall_tmr (
        .clk_i  (FCB_CLK),
        .rst_ni (FCB_RST_N),
        .inc_i  (stalling),
        .clr_i  (!stalling),
        .tmo_o  (stall_tmo)
    );
`else
    assign stall_tmo = 1'b0;
`endif

    // Next-state, latch and CSR request decode.
    always_comb begin
        state_d      = state_q;
        offset_d     = offset_q;
        wdata_d      = wdata_q;
        strb_d       = strb_q;
        we_d         = we_q;
        in_win_d     = in_win_q;
        abort_d      = abort_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        chks_d       = chks_q;
        APBS_CSR_req = 1'b0;

        unique case (state_q)
            StIdle: begin
                // PSEL with PENABLE already high is a protocol error: ignored.
                if (apb.psel && !apb.penable) begin
                    offset_d = apb.paddr - BASE_ADDR;
                    wdata_d  = apb.pwdata;
                    strb_d   = apb.pwrite ? apb.pstrb : '0;
                    we_d     = apb.pwrite;
                    in_win_d = in_window(64'(apb.paddr), 64'(BASE_ADDR), 64'(LAST_ADDR));
                    abort_d  = 1'b0;
                    state_d  = StReq;
                end
            end
            StReq: begin
                if (!apb.psel) begin
                    state_d = StIdle;
                end else if (!in_win_q || (stalling && stall_tmo)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else if (!stalling) begin
                    APBS_CSR_req = 1'b1;
                    state_d      = StWait;
                end
            end
            StWait: begin
                if (!apb.psel) begin
                    abort_d = 1'b1;
                end
                if (CSR_APBS_ack) begin
                    rdata_d = we_q ? '0 : CSR_APBS_rdata;
                    err_d   = CSR_APBS_err;
                    if (we_q && !CSR_APBS_err) begin
                        chks_d = wdata_q;
                    end
                    // A master that walked away gets no PREADY.
                    state_d = (abort_q || !apb.psel) ? StIdle : StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and latched transfer registers.
    always_ff @(posedge FCB_CLK or negedge FCB_RST_N) begin
        if (!FCB_RST_N) begin
            state_q  <= StIdle;
            offset_q <= '0;
            wdata_q  <= '0;
            strb_q   <= '0;
            we_q     <= 1'b0;
            in_win_q <= 1'b0;
            abort_q  <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            chks_q   <= '0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            wdata_q  <= wdata_d;
            strb_q   <= strb_d;
            we_q     <= we_d;
            in_win_q <= in_win_d;
            abort_q  <= abort_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            chks_q   <= chks_d;
        end
    end

    // Response is only presented in RESP; everything else reads as zero.
    assign apb.pready   = (state_q == StResp);
    assign apb.pslverr  = (state_q == StResp) && err_q;
    assign apb.prdata   = (state_q == StResp) ? rdata_q : '0;

    assign APBS_CSR_we      = we_q;
    assign APBS_CSR_addr    = offset_q;
    assign APBS_CSR_wdata   = wdata_q;
    assign APBS_CSR_wstrb   = strb_q;
    assign fAPBS_CHKS_wdata = chks_q;
endmodule
